pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator for the RISC-V core: the next generation of the single-width PC unit. It adds a configurable width and reset vector, a multi-line interrupt front end with sticky pending bits, trap entry with a saved return PC (`epc`), an MRET return path, and misaligned-target rejection. It sits between the control unit, which drives `nextPCop`/`nextPC`, and the instruction-fetch port, which consumes `PC`.

## Interface
Parameters:
- `XLEN`, 32: PC/address width (≥ 8).
- `RESET_VEC`, 0: value loaded into `PC` on `rst` and on the RESET op.
- `TRAP_BASE`, 32'h00000100: trap entry address; must be 4-byte aligned.
- `NUM_IRQ`, 4: number of interrupt lines (1..16).

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `nextPC` in XLEN: jump/branch target for ASSIGN.
- `nextPCop` in 3: 000 NOP, 001 INC, 010 ASSIGN, 011 RESET, 100 MRET; 101–111 behave as NOP.
- `irq` in NUM_IRQ: level-sensitive interrupt requests.
- `irqEn` in 1: global interrupt enable.
- `PC` out XLEN: current PC.
- `epc` out XLEN: saved return address.
- `cause` out 4: index of the last taken interrupt.
- `inTrap` out 1: handler active; no nesting while set.
- `intAck` out 1: one-cycle pulse on trap entry.
- `misaligned` out 1: one-cycle pulse when an ASSIGN is rejected.

## Operation
- Reset values: `PC`=RESET_VEC; `epc`=0; `cause`=0; pending=0; `inTrap`=0; `intAck`=0; `misaligned`=0.
- Pending register:
  - Each cycle, pending |= irq.
  - Taking an interrupt clears only its own bit, and only if that line is low in the same cycle (set wins).
  - Pending bits accumulate even when `irqEn`=0 or `inTrap`=1.
- Instruction boundary: a cycle in which `nextPCop` is INC, or is ASSIGN with an aligned target.
- Trap entry is taken at a boundary when `irqEn`=1, `inTrap`=0 and pending≠0. In that cycle:
  - `epc` ← the PC the op would have produced (PC+4 for INC, `nextPC` for ASSIGN).
  - `PC` ← trap target.
  - `cause` ← lowest set pending index.
  - `inTrap` ← 1 and `intAck` ← 1.
- Ops when no trap is taken:
  - NOP: PC holds.
  - INC: PC ← PC+4, modulo 2^XLEN (wrap at all-ones-minus-3 to 0).
  - ASSIGN with `nextPC[1:0]`≠0: PC holds, `misaligned` pulses, and the cycle is not a boundary.
  - RESET: PC ← RESET_VEC, `inTrap` ← 0, pending cleared. `epc` and `cause` are kept.
  - MRET with `inTrap`=1: PC ← `epc`, `inTrap` ← 0.
  - MRET with `inTrap`=0: treated as NOP.
- Priority: `rst` > RESET op > trap entry > normal op.
- Irq sources must deassert before the handler issues MRET; otherwise the same interrupt re-enters at the next boundary.

## Timing
- All outputs are registered. An op applied in cycle N is visible on `PC` in cycle N+1.
- Interrupt latency: an irq high at edge N is pending from N+1. The earliest trap entry is at the first boundary at or after N+1, so `PC`=target one cycle after that boundary.
- `intAck` and `misaligned` are high for exactly one cycle each.
- `rst` asserted mid-trap returns every register to its reset value immediately, without waiting for a clock edge.
- `irqEn` is sampled only in the cycle of the boundary.

## Configuration
- `PC_GEN_VECTORED_EN`:
  - Defined: trap target = TRAP_BASE + 4·`cause`, with the addition done at XLEN width.
  - Undefined: every interrupt targets TRAP_BASE.
  - `cause`, `epc` and all other behaviour are identical in both modes.

## Test plan
- Reset and increment: with RESET_VEC=0x80, release `rst`, then apply INC ×3 → `PC` reads 0x80, 0x84, 0x88, 0x8C.
- Assign and misaligned: ASSIGN with 0x200 → `PC`=0x200. ASSIGN with 0x202 → `PC` stays 0x200 and `misaligned` pulses for one cycle.
- Trap entry and return: with `irqEn`=1 and PC=0x40, pulse irq[2] for one cycle, then apply INC → `epc`=0x44, `cause`=2, `intAck` pulses, and `PC`=0x100 (0x108 with `PC_GEN_VECTORED_EN`). Apply INC, then MRET → `PC`=0x44 and `inTrap`=0.
- Priority and masking: irq[1] and irq[3] rise together → `cause`=1 first. After MRET, the next boundary takes `cause`=3. With `irqEn`=0, both stay pending and no trap is taken.
- Wrap and reset interplay: PC=0xFFFFFFFC, apply INC → `PC`=0. Assert `rst` asynchronously while `inTrap`=1 → `PC`=RESET_VEC, `inTrap`=0, pending=0 before the next edge.

Source files
------------

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - program-counter generator with sticky interrupts, trap entry and MRET
// Optional vectored trap targets under `PC_GEN_VECTORED_EN.
module pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_BASE = XLEN'(32'h0000_0100),
  parameter int              NUM_IRQ   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [XLEN-1:0]     nextPC,
  input  logic [2:0]          nextPCop,
  input  logic [NUM_IRQ-1:0]  irq,
  input  logic                irqEn,
  output logic [XLEN-1:0]     PC,
  output logic [XLEN-1:0]     epc,
  output logic [3:0]          cause,
  output logic                inTrap,
  output logic                intAck,
  output logic                misaligned
);

  localparam logic [2:0] OP_INC    = 3'b001;
  localparam logic [2:0] OP_ASSIGN = 3'b010;
  localparam logic [2:0] OP_RESET  = 3'b011;
  localparam logic [2:0] OP_MRET   = 3'b100;

  logic [NUM_IRQ-1:0] pending, pendingNext, lowMask;
  logic [XLEN-1:0]    pcNext, epcNext, incPC, opTarget, trapTarget;
  logic [3:0]         causeNext, lowIdx;
  logic               inTrapNext, intAckNext, misNext;
  logic               aligned, boundary, takeTrap;

  // Lowest-numbered pending line wins; the downward scan leaves the lowest index last.
  always_comb begin
    lowIdx = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) lowIdx = 4'(i);
    end
  end

  assign lowMask  = pending & (~pending + NUM_IRQ'(1));
  assign incPC    = PC + XLEN'(4);
  assign aligned  = (nextPC[1:0] == 2'b00);
  assign boundary = (nextPCop == OP_INC) || ((nextPCop == OP_ASSIGN) && aligned);
  assign opTarget = (nextPCop == OP_INC) ? incPC : nextPC;
  assign takeTrap = boundary && irqEn && !inTrap && (|pending);

`ifdef PC_GEN_VECTORED_EN
  assign trapTarget = TRAP_BASE + (XLEN'(lowIdx) << 2);
`else
  assign trapTarget = TRAP_BASE;
`endif

  always_comb begin
    pcNext      = PC;
    epcNext     = epc;
    causeNext   = cause;
    inTrapNext  = inTrap;
    intAckNext  = 1'b0;
    misNext     = 1'b0;
    pendingNext = pending | irq;

    if (nextPCop == OP_RESET) begin
      pcNext      = RESET_VEC;
      inTrapNext  = 1'b0;
      pendingNext = '0;
    end else if (takeTrap) begin
      epcNext     = opTarget;
      pcNext      = trapTarget;
      causeNext   = lowIdx;
      inTrapNext  = 1'b1;
      intAckNext  = 1'b1;
      // A line still asserted this cycle keeps its pending bit set.
      pendingNext = (pending & ~(lowMask & ~irq)) | irq;
    end else begin
      case (nextPCop)
        OP_INC:    pcNext = incPC;
        OP_ASSIGN: begin
          if (aligned) pcNext = nextPC;
          else         misNext = 1'b1;
        end
        OP_MRET: begin
          if (inTrap) begin
            pcNext     = epc;
            inTrapNext = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC         <= RESET_VEC;
      epc        <= '0;
      cause      <= 4'd0;
      pending    <= '0;
      inTrap     <= 1'b0;
      intAck     <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      PC         <= pcNext;
      epc        <= epcNext;
      cause      <= causeNext;
      pending    <= pendingNext;
      inTrap     <= inTrapNext;
      intAck     <= intAckNext;
      misaligned <= misNext;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed self-checking bench for pc_gen
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] nextPC;
  logic [2:0]  nextPCop;
  logic [3:0]  irq;
  logic        irqEn;
  logic [31:0] PC, epc;
  logic [3:0]  cause;
  logic        inTrap, intAck, misaligned;

  int tests  = 0;
  int failed = 0;

  localparam logic [2:0] NOP = 3'b000, INC = 3'b001, ASSIGN = 3'b010, RST = 3'b011, MRET = 3'b100;

`ifdef PC_GEN_VECTORED_EN
  localparam bit VEC = 1'b1;
`else
  localparam bit VEC = 1'b0;
`endif

  pc_gen #(.XLEN(32), .RESET_VEC(32'h80), .TRAP_BASE(32'h100), .NUM_IRQ(4)) dut (
    .clk(clk), .rst(rst), .nextPC(nextPC), .nextPCop(nextPCop), .irq(irq), .irqEn(irqEn),
    .PC(PC), .epc(epc), .cause(cause), .inTrap(inTrap), .intAck(intAck), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] tgt(input int c);
    return VEC ? (32'h100 + 32'(c) * 4) : 32'h100;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; nextPC = '0; nextPCop = NOP; irq = '0; irqEn = 1'b0;
    #12;
    chk("rst_pc", PC, 32'h80);
    chk("rst_epc", epc, 0);
    chk("rst_cause", 32'(cause), 0);
    chk("rst_intrap", 32'(inTrap), 0);
    chk("rst_intack", 32'(intAck), 0);
    chk("rst_mis", 32'(misaligned), 0);
    rst = 1'b0;

    nextPCop = INC;
    step(); chk("inc1", PC, 32'h84);
    step(); chk("inc2", PC, 32'h88);
    step(); chk("inc3", PC, 32'h8C);

    nextPCop = ASSIGN; nextPC = 32'h200;
    step(); chk("assign", PC, 32'h200); chk("assign_mis", 32'(misaligned), 0);
    nextPC = 32'h202;
    step(); chk("mis_pc", PC, 32'h200); chk("mis_pulse", 32'(misaligned), 1);
    nextPCop = NOP;
    step(); chk("mis_drop", 32'(misaligned), 0); chk("nop_hold", PC, 32'h200);

    // Trap entry and return
    nextPCop = ASSIGN; nextPC = 32'h40;
    step(); chk("pc40", PC, 32'h40);
    nextPCop = NOP; irqEn = 1'b1; irq = 4'b0100;
    step(); chk("nop_no_trap", 32'(inTrap), 0);
    irq = 4'b0000; nextPCop = INC;
    step();
    chk("trap_pc", PC, tgt(2));
    chk("trap_epc", epc, 32'h44);
    chk("trap_cause", 32'(cause), 2);
    chk("trap_intrap", 32'(inTrap), 1);
    chk("trap_ack", 32'(intAck), 1);
    step(); chk("hdl_pc", PC, tgt(2) + 4); chk("ack_drop", 32'(intAck), 0);
    nextPCop = MRET;
    step(); chk("mret_pc", PC, 32'h44); chk("mret_intrap", 32'(inTrap), 0);

    // Priority: lines 1 and 3 together
    nextPCop = NOP; irq = 4'b1010;
    step();
    irq = 4'b0000; nextPCop = INC;
    step(); chk("prio_cause1", 32'(cause), 1); chk("prio_epc1", epc, 32'h48); chk("prio_pc1", PC, tgt(1));
    step(); chk("no_nest_cause", 32'(cause), 1); chk("no_nest_pc", PC, tgt(1) + 4);
    nextPCop = MRET;
    step(); chk("prio_ret", PC, 32'h48);
    nextPCop = INC;
    step(); chk("prio_cause3", 32'(cause), 3); chk("prio_epc3", epc, 32'h4C); chk("prio_pc3", PC, tgt(3));
    nextPCop = MRET;
    step(); chk("prio_ret3", PC, 32'h4C);

    // Masking: pending accumulates while irqEn=0
    irqEn = 1'b0; nextPCop = NOP; irq = 4'b1010;
    step();
    irq = 4'b0000; nextPCop = INC;
    step(); chk("mask_pc", PC, 32'h50); chk("mask_intrap", 32'(inTrap), 0);
    step(); chk("mask_pc2", PC, 32'h54); chk("mask_ack", 32'(intAck), 0);
    irqEn = 1'b1;
    step(); chk("unmask_cause", 32'(cause), 1); chk("unmask_epc", epc, 32'h58);

    // RESET op clears inTrap and pending, keeps epc/cause
    nextPCop = RST;
    step(); chk("rop_pc", PC, 32'h80); chk("rop_intrap", 32'(inTrap), 0);
    chk("rop_epc", epc, 32'h58); chk("rop_cause", 32'(cause), 1);
    nextPCop = INC;
    step(); chk("rop_pend_clr", PC, 32'h84); chk("rop_no_trap", 32'(inTrap), 0);

    // Wrap
    nextPCop = ASSIGN; nextPC = 32'hFFFF_FFFC;
    step(); chk("pre_wrap", PC, 32'hFFFF_FFFC);
    nextPCop = INC; irqEn = 1'b0;
    step(); chk("wrap", PC, 32'h0);

    // Asynchronous reset mid-trap
    irqEn = 1'b1; nextPCop = NOP; irq = 4'b0011;
    step();
    irq = 4'b0000; nextPCop = INC;
    step(); chk("pre_rst_trap", 32'(inTrap), 1); chk("pre_rst_epc", epc, 32'h4);
    nextPCop = NOP;
    #2 rst = 1'b1;
    #1;
    chk("arst_pc", PC, 32'h80);
    chk("arst_intrap", 32'(inTrap), 0);
    chk("arst_epc", epc, 0);
    chk("arst_cause", 32'(cause), 0);
    rst = 1'b0;
    nextPCop = INC;
    step(); chk("arst_pend_clr", PC, 32'h84); chk("arst_no_trap", 32'(inTrap), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
